// File: rtl/dense_bias_loader.sv
// Packs a serial byte upload into little-endian 32-bit biases and writes them,
// one strobe per word, into the dense-bias RAM; pulses done after the last word.
module dense_bias_loader #(
  parameter int NUM_BIASES = 10,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [7:0]            in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  output logic [31:0]           wr_data,
  output logic                  wr_en,
  output logic                  busy,
  output logic                  done
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    FINISH = 2'd2
  } state_e;

  localparam logic [ADDR_WIDTH-1:0] LAST_WORD = ADDR_WIDTH'(NUM_BIASES - 1);
  localparam logic [ADDR_WIDTH-1:0] WORD_ONE  = ADDR_WIDTH'(1);

  state_e                state_q, state_d;
  logic [1:0]            byte_idx_q, byte_idx_d;
  logic [ADDR_WIDTH-1:0] word_idx_q, word_idx_d;
  // Only bytes 0..2 need storage; byte 3 is taken straight from in_data.
  logic [23:0]           shift_q, shift_d;
  logic                  in_ready_q, in_ready_d;
  logic                  wr_en_q, wr_en_d;
  logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
  logic [31:0]           wr_data_q, wr_data_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  xfer_s;

  assign xfer_s = in_valid & in_ready_q;

  // Next-state, packing and write-strobe generation.
  always_comb begin
    state_d    = state_q;
    byte_idx_d = byte_idx_q;
    word_idx_d = word_idx_q;
    shift_d    = shift_q;
    wr_en_d    = 1'b0;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d    = LOAD;
          byte_idx_d = 2'd0;
          word_idx_d = {ADDR_WIDTH{1'b0}};
          shift_d    = 24'd0;
        end else begin
          state_d = IDLE;
        end
      end
      LOAD: begin
        if (xfer_s) begin
          case (byte_idx_q)
            2'd0: shift_d[7:0]   = in_data;
            2'd1: shift_d[15:8]  = in_data;
            2'd2: shift_d[23:16] = in_data;
            default: begin
              wr_en_d    = 1'b1;
              wr_addr_d  = word_idx_q;
              wr_data_d  = {in_data, shift_q};
            end
          endcase
          byte_idx_d = byte_idx_q + 2'd1;
          if (byte_idx_q == 2'd3) begin
            if (word_idx_q == LAST_WORD) begin
              state_d    = FINISH;
              word_idx_d = {ADDR_WIDTH{1'b0}};
            end else begin
              word_idx_d = word_idx_q + WORD_ONE;
            end
          end else begin
            word_idx_d = word_idx_q;
          end
        end else begin
          state_d = LOAD;
        end
      end
      FINISH: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Status outputs are registered; done/busy trail the state by one cycle so
    // done lands one cycle after the final write strobe.
    in_ready_d = (state_d == LOAD);
    busy_d     = (state_q != IDLE);
    done_d     = (state_q == FINISH);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      byte_idx_q <= 2'd0;
      word_idx_q <= {ADDR_WIDTH{1'b0}};
      shift_q    <= 24'd0;
      in_ready_q <= 1'b0;
      wr_en_q    <= 1'b0;
      wr_addr_q  <= {ADDR_WIDTH{1'b0}};
      wr_data_q  <= 32'd0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      byte_idx_q <= byte_idx_d;
      word_idx_q <= word_idx_d;
      shift_q    <= shift_d;
      in_ready_q <= in_ready_d;
      wr_en_q    <= wr_en_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign in_ready = in_ready_q;
  assign wr_en    = wr_en_q;
  assign wr_addr  = wr_addr_q;
  assign wr_data  = wr_data_q;
  assign busy     = busy_q;
  assign done     = done_q;

endmodule

// File: tb/tb_dense_bias_loader.sv
// Directed bench for dense_bias_loader: full loads, gapped input, IDLE drops,
// mid-load reset, stray start and back-to-back loads.
module tb_dense_bias_loader;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  wr_addr;
  logic [31:0] wr_data;
  logic        wr_en;
  logic        busy;
  logic        done;

  int total = 0;
  int bad   = 0;

  logic [3:0]  aq[$];
  logic [31:0] dq[$];
  int          done_cnt   = 0;
  int          consec_cnt = 0;
  logic        prev_wr_en = 1'b0;

  dense_bias_loader #(.NUM_BIASES(10), .ADDR_WIDTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .in_data(in_data),
    .in_valid(in_valid), .in_ready(in_ready), .wr_addr(wr_addr),
    .wr_data(wr_data), .wr_en(wr_en), .busy(busy), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Record RAM writes and done pulses away from the active edge.
  always @(negedge clk) begin
    if (wr_en) begin
      aq.push_back(wr_addr);
      dq.push_back(wr_data);
    end
    if (wr_en && prev_wr_en) consec_cnt++;
    if (done) done_cnt++;
    prev_wr_en <= wr_en;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    in_data  = b;
    in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("in_ready_wait", {31'd0, in_ready}, 32'd1);
    tick();
    in_valid = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  function automatic logic [31:0] exp_word(input logic [7:0] base, input bit cnst, input int w);
    logic [7:0] b [4];
    for (int k = 0; k < 4; k++) b[k] = cnst ? base : base + 8'(4 * w + k);
    return {b[3], b[2], b[1], b[0]};
  endfunction

  // One complete load of 40 bytes with end-of-load timing and content checks.
  task automatic run_load(input logic [7:0] base, input bit cnst, input bit gaps,
                          input int extra_at, input string tag);
    int first = aq.size();
    pulse_start();
    for (int i = 0; i < 40; i++) begin
      send_byte(cnst ? base : base + 8'(i));
      if (i < 39 && gaps) repeat ($urandom_range(0, 5)) tick();
      if (i == extra_at) pulse_start();
    end
    chk({tag, "_last_wr_en"}, {31'd0, wr_en}, 32'd1);
    chk({tag, "_last_done0"}, {31'd0, done}, 32'd0);
    chk({tag, "_last_ready"}, {31'd0, in_ready}, 32'd0);
    tick();
    chk({tag, "_done_hi"}, {31'd0, done}, 32'd1);
    chk({tag, "_busy_hi"}, {31'd0, busy}, 32'd1);
    chk({tag, "_wr_en_lo"}, {31'd0, wr_en}, 32'd0);
    tick();
    chk({tag, "_done_lo"}, {31'd0, done}, 32'd0);
    chk({tag, "_busy_lo"}, {31'd0, busy}, 32'd0);
    chk({tag, "_n_writes"}, 32'(aq.size() - first), 32'd10);
    for (int w = 0; w < 10 && first + w < aq.size(); w++) begin
      chk({tag, "_addr"}, {28'd0, aq[first + w]}, 32'(w));
      chk({tag, "_data"}, dq[first + w], exp_word(base, cnst, w));
    end
  endtask

  initial begin
    int first;
    int dsnap;
    rst_n    = 1'b0;
    start    = 1'b0;
    in_data  = 8'd0;
    in_valid = 1'b0;
    repeat (3) tick();
    chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
    chk("rst_wr_en", {31'd0, wr_en}, 32'd0);
    chk("rst_wr_addr", {28'd0, wr_addr}, 32'd0);
    chk("rst_wr_data", wr_data, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    rst_n = 1'b1;
    tick();

    // Test 1: back-to-back 0x00..0x27
    first = aq.size();
    run_load(8'h00, 1'b0, 1'b0, -1, "t1");
    chk("t1_addr0_word", dq[first], 32'h03020100);
    chk("t1_addr9_word", dq[first + 9], 32'h27262524);
    chk("t1_addr9", {28'd0, aq[first + 9]}, 32'd9);
    chk("t1_hold_addr", {28'd0, wr_addr}, 32'd9);
    chk("t1_hold_data", wr_data, 32'h27262524);

    // Test 2: same bytes with random gaps
    run_load(8'h00, 1'b0, 1'b1, -1, "t2");

    // Test 3: bytes in IDLE are dropped, including the one coincident with start
    first = aq.size();
    in_valid = 1'b1;
    in_data  = 8'hAA;
    for (int i = 0; i < 6; i++) begin
      chk("t3_idle_ready", {31'd0, in_ready}, 32'd0);
      tick();
    end
    chk("t3_idle_writes", 32'(aq.size() - first), 32'd0);
    chk("t3_start_ready", {31'd0, in_ready}, 32'd0);
    run_load(8'h11, 1'b1, 1'b0, -1, "t3");
    chk("t3_word0", dq[first], 32'h11111111);

    // Test 4: reset after 13 bytes
    first = aq.size();
    pulse_start();
    for (int i = 0; i < 13; i++) send_byte(8'hC0 + 8'(i));
    tick();
    rst_n = 1'b0;
    tick();
    chk("t4_rst_in_ready", {31'd0, in_ready}, 32'd0);
    chk("t4_rst_wr_en", {31'd0, wr_en}, 32'd0);
    chk("t4_rst_wr_addr", {28'd0, wr_addr}, 32'd0);
    chk("t4_rst_wr_data", wr_data, 32'd0);
    chk("t4_rst_busy", {31'd0, busy}, 32'd0);
    chk("t4_rst_done", {31'd0, done}, 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    chk("t4_writes_before_rst", 32'(aq.size() - first), 32'd3);
    chk("t4_word2", dq[first + 2], 32'hCBCAC9C8);
    run_load(8'h40, 1'b0, 1'b0, -1, "t4");

    // Test 5: stray start after byte 17
    run_load(8'h00, 1'b0, 1'b0, 17, "t5");

    // Test 6: second load starts the cycle after done
    dsnap = done_cnt;
    run_load(8'h00, 1'b0, 1'b0, -1, "t6a");
    run_load(8'h80, 1'b0, 1'b0, -1, "t6b");
    chk("t6_done_pulses", 32'(done_cnt - dsnap), 32'd2);

    chk("no_consecutive_wr_en", 32'(consec_cnt), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
